// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared run states and default widths for the sequence detector (no ports)
package seq_det_pkg;
  localparam int MAX_LEN = 8;
  localparam int LEN_W = 4;
  localparam int WIN_W = 16;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: history shift register, length-masked compare and registered hit; en samples x, clr wipes history/hit, overlap keeps history after a match, match is the combinational detect for the current edge
module seq_det_core #(
  parameter int MAX_LEN = seq_det_pkg::MAX_LEN,
  parameter int LEN_W = seq_det_pkg::LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               overlap,
  input  logic               x,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               match,
  output logic               hit
);
  logic [MAX_LEN-1:0] hist, hist_n, mask;
  logic [MAX_LEN:0] one_sh;
  logic [LEN_W-1:0] bits_seen;
  assign hist_n = {hist[MAX_LEN-2:0], x};
  assign one_sh = (MAX_LEN+1)'(1) << len;
  assign mask = MAX_LEN'(one_sh - (MAX_LEN+1)'(1));
  assign match = en && ((LEN_W+1)'(bits_seen) + (LEN_W+1)'(1) >= (LEN_W+1)'(len))
                 && (((hist_n ^ pattern) & mask) == '0);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      bits_seen <= '0;
      hit <= 1'b0;
    end else begin
      hit <= match;
      if (en) begin
        hist <= (match && !overlap) ? '0 : hist_n;
        bits_seen <= (match && !overlap) ? '0 : (bits_seen < len) ? bits_seen + LEN_W'(1) : bits_seen;
      end
    end
  end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run controller (FSM, config, window and match counters) around seq_det_core; host cfg_*/start/abort in, serial x/x_valid in, busy/hit/done/match_cnt out; SEQ_DET_FIRST_IDX_EN adds first_vld/first_idx
module seq_det_ctrl #(
  parameter int MAX_LEN = seq_det_pkg::MAX_LEN,
  parameter int LEN_W = seq_det_pkg::LEN_W,
  parameter int WIN_W = seq_det_pkg::WIN_W,
  parameter int CNT_W = seq_det_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               busy,
  output logic               hit,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt
`ifdef SEQ_DET_FIRST_IDX_EN
  ,
  output logic               first_vld,
  output logic [WIN_W-1:0]   first_idx
`endif
);
  import seq_det_pkg::*;
  state_t state;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic overlap, cfg_ok, go, stop, en, match;
  logic [WIN_W-1:0] window, idx, win_eff;
  assign cfg_ok = cfg_we && state != RUN;
  assign go = start && state != RUN;
  assign stop = abort && state == RUN;
  assign en = state == RUN && x_valid && !abort;
  assign win_eff = cfg_ok ? cfg_window : window;
  assign busy = state == RUN;
  assign done = state == DONE;
  seq_det_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
    .clk(clk), .rst(rst), .en(en), .clr(go || stop), .overlap(overlap),
    .x(x), .len(len), .pattern(pattern), .match(match), .hit(hit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pattern <= '0;
      len <= LEN_W'(MAX_LEN);
      overlap <= 1'b0;
      window <= '0;
      idx <= '0;
      match_cnt <= '0;
    end else begin
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len <= (cfg_len == '0) ? LEN_W'(1) : (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        overlap <= cfg_overlap;
        window <= cfg_window;
      end
      if (go) begin
        state <= (win_eff == '0) ? DONE : RUN;
        idx <= '0;
        match_cnt <= '0;
      end else if (stop) begin
        state <= IDLE;
        match_cnt <= '0;
      end else if (en) begin
        idx <= idx + WIN_W'(1);
        if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        if (idx + WIN_W'(1) == window) state <= DONE;
      end
    end
  end
`ifdef SEQ_DET_FIRST_IDX_EN
  always_ff @(posedge clk) begin
    if (rst || go || stop) begin
      first_vld <= 1'b0;
      first_idx <= '0;
    end else if (match && !first_vld) begin
      first_vld <= 1'b1;
      first_idx <= idx;
    end
  end
`endif
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: table-driven directed bench for seq_det_ctrl with hand-written abort/reset/zero-window sequences
module tb_seq_det_ctrl;
  logic clk = 1'b0;
  logic rst, cfg_we, cfg_overlap, start, abort, x, x_valid, busy, hit, done;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [15:0] cfg_window;
  logic [1:0] match_cnt;
  int checks = 0, failures = 0;
`ifdef SEQ_DET_FIRST_IDX_EN
  logic first_vld;
  logic [15:0] first_idx;
`endif
  always #5 clk = ~clk;
  seq_det_ctrl #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_window(cfg_window), .start(start), .abort(abort),
    .x(x), .x_valid(x_valid), .busy(busy), .hit(hit), .done(done), .match_cnt(match_cnt)
`ifdef SEQ_DET_FIRST_IDX_EN
    , .first_vld(first_vld), .first_idx(first_idx)
`endif
  );
  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic ovl;
    logic [15:0] win;
    logic [15:0] bits;
    int n;
    int gap;
    logic junk;
    logic [15:0] hits;
    logic [1:0] cnt;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic outs(input string tag, input logic h, input logic b, input logic d, input logic [1:0] c);
    chk({tag, "_hit"}, 32'(hit), 32'(h));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_cnt"}, 32'(match_cnt), 32'(c));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg_start(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [15:0] w);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_window = w; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    outs("start", 1'b0, w != 0, w == 0, 2'd0);
  endtask
  task automatic sample(input logic b);
    x_valid = 1'b1; x = b;
    tick();
    x_valid = 1'b0;
  endtask
  initial begin
    int run_cnt;
    tbl[0] = '{8'h09, 4'd4, 1'b1, 16'd7, 16'h0049, 7, 0, 1'b0, 16'h0048, 2'd2};
    tbl[1] = '{8'h09, 4'd4, 1'b0, 16'd7, 16'h0049, 7, 0, 1'b0, 16'h0008, 2'd1};
    tbl[2] = '{8'h09, 4'd4, 1'b1, 16'd7, 16'h0049, 7, 3, 1'b0, 16'h0048, 2'd2};
    tbl[3] = '{8'h09, 4'd4, 1'b1, 16'd7, 16'h0049, 7, 0, 1'b1, 16'h0048, 2'd2};
    tbl[4] = '{8'h01, 4'd1, 1'b0, 16'd5, 16'h001F, 5, 0, 1'b0, 16'h001F, 2'd3};
    tbl[5] = '{8'h00, 4'd0, 1'b1, 16'd4, 16'h0002, 4, 0, 1'b0, 16'h000D, 2'd3};
    tbl[6] = '{8'hA5, 4'd15, 1'b1, 16'd9, 16'h01A5, 9, 0, 1'b0, 16'h0080, 2'd1};
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_window = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    tick(); tick();
    outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    for (int r = 0; r < 7; r++) begin
      cfg_start(tbl[r].pat, tbl[r].len, tbl[r].ovl, tbl[r].win);
      run_cnt = 0;
      for (int i = 0; i < tbl[r].n; i++) begin
        if (tbl[r].junk) begin
          cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd2; cfg_overlap = 1'b0; cfg_window = 16'd3;
        end
        sample(tbl[r].bits[i]);
        cfg_we = 1'b0;
        if (tbl[r].hits[i]) run_cnt = (run_cnt < 3) ? run_cnt + 1 : 3;
        outs($sformatf("row%0d_s%0d", r, i), tbl[r].hits[i], i != tbl[r].n - 1, i == tbl[r].n - 1, 2'(run_cnt));
        for (int g = 0; g < tbl[r].gap; g++) begin
          x = 1'($urandom);
          tick();
          outs($sformatf("row%0d_gap%0d", r, i), 1'b0, i != tbl[r].n - 1, i == tbl[r].n - 1, 2'(run_cnt));
        end
      end
      x_valid = 1'b1; x = 1'b1;
      tick();
      x_valid = 1'b0;
      outs($sformatf("row%0d_end", r), 1'b0, 1'b0, 1'b1, tbl[r].cnt);
`ifdef SEQ_DET_FIRST_IDX_EN
      begin
        int fi = 0;
        for (int k = 15; k >= 0; k--) if (tbl[r].hits[k]) fi = k;
        chk($sformatf("row%0d_first_vld", r), 32'(first_vld), 32'(tbl[r].hits != 0));
        if (tbl[r].hits != 0) chk($sformatf("row%0d_first_idx", r), 32'(first_idx), 32'(fi));
      end
`endif
    end
    cfg_start(8'h01, 4'd1, 1'b0, 16'd0);
    sample(1'b1);
    outs("zwin_a", 1'b0, 1'b0, 1'b1, 2'd0);
    sample(1'b1);
    outs("zwin_b", 1'b0, 1'b0, 1'b1, 2'd0);
    cfg_start(8'h01, 4'd1, 1'b0, 16'd3);
    sample(1'b1);
    outs("abort_s0", 1'b1, 1'b1, 1'b0, 2'd1);
    sample(1'b1);
    outs("abort_s1", 1'b1, 1'b1, 1'b0, 2'd2);
    abort = 1'b1;
    sample(1'b1);
    abort = 1'b0;
    outs("abort_s2", 1'b0, 1'b0, 1'b0, 2'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outs("abort_idle", 1'b0, 1'b0, 1'b0, 2'd0);
    cfg_start(8'h01, 4'd1, 1'b0, 16'd1);
    sample(1'b1);
    outs("done_one", 1'b1, 1'b0, 1'b1, 2'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outs("abort_done", 1'b0, 1'b0, 1'b1, 2'd1);
    cfg_start(8'h01, 4'd1, 1'b0, 16'd5);
    sample(1'b1);
    outs("rst_pre", 1'b1, 1'b1, 1'b0, 2'd1);
    rst = 1'b1;
    sample(1'b1);
    rst = 1'b0;
    outs("rst_mid", 1'b0, 1'b0, 1'b0, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    outs("rst_cfg", 1'b0, 1'b0, 1'b1, 2'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
